// File: rtl/pipeline_repeat_scheduler.sv
// rtl/pipeline_repeat_scheduler.sv - round-robin arbiter that replays each granted word count times
module pipeline_repeat_scheduler #(
    parameter int WORD_WIDTH         = 8,
    parameter int INPUT_COUNT        = 3,
    parameter int MAX_REPEAT_COUNT   = 4,
    localparam int REPEAT_COUNT_WIDTH = $clog2(MAX_REPEAT_COUNT) + 1,
    localparam int SOURCE_WIDTH       = ($clog2(INPUT_COUNT) > 1) ? $clog2(INPUT_COUNT) : 1
) (
    input  logic                                       clock,
    input  logic                                       clear,
    input  logic [INPUT_COUNT-1:0]                     input_valid,
    output logic [INPUT_COUNT-1:0]                     input_ready,
    input  logic [INPUT_COUNT*WORD_WIDTH-1:0]          input_data,
    input  logic [INPUT_COUNT*REPEAT_COUNT_WIDTH-1:0]  input_repeat_count,
    output logic                                       output_valid,
    input  logic                                       output_ready,
    output logic [WORD_WIDTH-1:0]                      output_data,
    output logic [SOURCE_WIDTH-1:0]                    output_source,
    output logic                                       output_last,
    output logic                                       busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                        state_q;
    logic [SOURCE_WIDTH-1:0]       ptr_q;
    logic [SOURCE_WIDTH-1:0]       ptr_d;
    logic [REPEAT_COUNT_WIDTH-1:0] remaining_q;
    logic [WORD_WIDTH-1:0]         data_q;
    logic [SOURCE_WIDTH-1:0]       source_q;

    logic                          any_valid;
    logic                          hi_found;
    logic [SOURCE_WIDTH-1:0]       hi_idx;
    logic [SOURCE_WIDTH-1:0]       lo_idx;
    logic [SOURCE_WIDTH-1:0]       grant;
    logic                          in_fire;
    logic [REPEAT_COUNT_WIDTH-1:0] count_sel;
    logic [REPEAT_COUNT_WIDTH-1:0] count_clamped;
    logic [WORD_WIDTH-1:0]         data_sel;

    // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index overall.
    always_comb begin
        any_valid = 1'b0;
        hi_found  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int i = INPUT_COUNT - 1; i >= 0; i--) begin
            if (input_valid[i]) begin
                any_valid = 1'b1;
                lo_idx    = SOURCE_WIDTH'(i);
                if (SOURCE_WIDTH'(i) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = SOURCE_WIDTH'(i);
                end
            end
        end
        grant = hi_found ? hi_idx : lo_idx;
    end

    assign in_fire = (state_q == IDLE) && any_valid && !clear;

    always_comb begin
        input_ready = '0;
        for (int i = 0; i < INPUT_COUNT; i++) begin
            input_ready[i] = in_fire && (grant == SOURCE_WIDTH'(i));
        end
    end

    assign count_sel     = input_repeat_count[grant*REPEAT_COUNT_WIDTH +: REPEAT_COUNT_WIDTH];
    assign count_clamped = (count_sel > REPEAT_COUNT_WIDTH'(MAX_REPEAT_COUNT))
                         ? REPEAT_COUNT_WIDTH'(MAX_REPEAT_COUNT) : count_sel;
    assign data_sel      = input_data[grant*WORD_WIDTH +: WORD_WIDTH];
    assign ptr_d         = (grant == SOURCE_WIDTH'(INPUT_COUNT - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            source_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_fire) begin
                        ptr_q <= ptr_d;
                        // A zero count sinks the word and leaves the arbiter free next cycle.
                        if (count_clamped != '0) begin
                            state_q     <= BUSY;
                            data_q      <= data_sel;
                            source_q    <= grant;
                            remaining_q <= count_clamped;
                        end
                    end
                end
                BUSY: begin
                    if (output_ready) begin
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == REPEAT_COUNT_WIDTH'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = (state_q == BUSY);
    assign output_valid  = busy;
    assign output_last   = busy && (remaining_q == REPEAT_COUNT_WIDTH'(1));
    assign output_data   = data_q;
    assign output_source = source_q;

endmodule

// File: tb/tb_pipeline_repeat_scheduler.sv
// tb/tb_pipeline_repeat_scheduler.sv - directed and model-checked bench for pipeline_repeat_scheduler
module tb_pipeline_repeat_scheduler;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int MX = 4;
    localparam int CW = 3;
    localparam int SW = 2;

    logic            clock = 1'b0;
    logic            clear;
    logic [N-1:0]    input_valid;
    logic [N-1:0]    input_ready;
    logic [N*W-1:0]  input_data;
    logic [N*CW-1:0] input_repeat_count;
    logic            output_valid;
    logic            output_ready;
    logic [W-1:0]    output_data;
    logic [SW-1:0]   output_source;
    logic            output_last;
    logic            busy;

    int errors = 0;
    int checks = 0;

    pipeline_repeat_scheduler #(
        .WORD_WIDTH(W),
        .INPUT_COUNT(N),
        .MAX_REPEAT_COUNT(MX)
    ) dut (
        .clock(clock),
        .clear(clear),
        .input_valid(input_valid),
        .input_ready(input_ready),
        .input_data(input_data),
        .input_repeat_count(input_repeat_count),
        .output_valid(output_valid),
        .output_ready(output_ready),
        .output_data(output_data),
        .output_source(output_source),
        .output_last(output_last),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] d, input logic [CW-1:0] c);
        input_data[i*W +: W]           = d;
        input_repeat_count[i*CW +: CW] = c;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ov"}, 32'(output_valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_last"}, 32'(output_last), 0);
    endtask

    int            copies;
    logic          pv, pl;
    logic [W-1:0]  pd;
    logic [SW-1:0] ps;
    int            mptr, mrem, msrc, g, c;
    logic          mbusy;
    logic [W-1:0]  mdata;
    logic [N-1:0]  er;

    initial begin
        clear = 1'b1;
        input_valid = '0;
        input_data = '0;
        input_repeat_count = '0;
        output_ready = 1'b0;
        #1;
        check("rst_ready", 32'(input_ready), 0);
        check("rst_data", 32'(output_data), 0);
        check("rst_src", 32'(output_source), 0);
        check_idle_zero("rst");
        tick();
        tick();
        clear = 1'b0;

        // Single request, count 3
        set_req(0, 8'hA5, 3'd3);
        input_valid = 3'b001;
        output_ready = 1'b1;
        #1;
        check("single_ready", 32'(input_ready), 32'b001);
        tick();
        input_valid = '0;
        check("single_c1_ov", 32'(output_valid), 1);
        check("single_c1_data", 32'(output_data), 32'hA5);
        check("single_c1_src", 32'(output_source), 0);
        check("single_c1_last", 32'(output_last), 0);
        check("single_c1_busy", 32'(busy), 1);
        tick();
        check("single_c2_data", 32'(output_data), 32'hA5);
        check("single_c2_last", 32'(output_last), 0);
        tick();
        check("single_c3_data", 32'(output_data), 32'hA5);
        check("single_c3_last", 32'(output_last), 1);
        tick();
        check_idle_zero("single_end");

        // Round robin with all three valid, count 1, starting from ptr 0
        clear = 1'b1;
        tick();
        clear = 1'b0;
        set_req(0, 8'h10, 3'd1);
        set_req(1, 8'h20, 3'd1);
        set_req(2, 8'h30, 3'd1);
        input_valid = 3'b111;
        for (int j = 0; j < 4; j++) begin
            g = j % N;
            #1;
            check($sformatf("rr%0d_ready", j), 32'(input_ready), 32'(1 << g));
            tick();
            check($sformatf("rr%0d_data", j), 32'(output_data), 32'((g + 1) * 16));
            check($sformatf("rr%0d_src", j), 32'(output_source), 32'(g));
            check($sformatf("rr%0d_last", j), 32'(output_last), 1);
            check($sformatf("rr%0d_busy_ready", j), 32'(input_ready), 0);
            tick();
        end

        // Zero count on req1 (ptr now 1), req2 count 2
        input_valid = 3'b110;
        set_req(1, 8'h55, 3'd0);
        set_req(2, 8'h66, 3'd2);
        #1;
        check("zero_ready1", 32'(input_ready), 32'b010);
        tick();
        input_valid = 3'b100;
        #1;
        check_idle_zero("zero_sunk");
        check("zero_ready2", 32'(input_ready), 32'b100);
        tick();
        input_valid = '0;
        check("zero_c1_data", 32'(output_data), 32'h66);
        check("zero_c1_src", 32'(output_source), 2);
        check("zero_c1_last", 32'(output_last), 0);
        tick();
        check("zero_c2_last", 32'(output_last), 1);
        tick();
        check_idle_zero("zero_end");

        // Clamp 7 -> 4 with toggling backpressure (ptr now 0, only req2 valid)
        set_req(2, 8'h77, 3'd7);
        input_valid = 3'b100;
        #1;
        check("clamp_ready", 32'(input_ready), 32'b100);
        tick();
        input_valid = '0;
        copies = 0;
        for (int i = 0; i < 12; i++) begin
            output_ready = (i % 2 == 0);
            #1;
            pv = output_valid;
            pd = output_data;
            ps = output_source;
            pl = output_last;
            if (output_valid && output_ready) copies++;
            tick();
            if (pv && !output_ready) begin
                check($sformatf("bp%0d_data", i), 32'(output_data), 32'(pd));
                check($sformatf("bp%0d_src", i), 32'(output_source), 32'(ps));
                check($sformatf("bp%0d_last", i), 32'(output_last), 32'(pl));
            end
        end
        check("clamp_copies", 32'(copies), 4);
        check_idle_zero("clamp_end");

        // Clear mid-burst after copy 2 of a count-4 word
        set_req(0, 8'h99, 3'd4);
        input_valid = 3'b001;
        output_ready = 1'b1;
        tick();
        input_valid = '0;
        tick();
        tick();
        check("mid_before_data", 32'(output_data), 32'h99);
        check("mid_before_last", 32'(output_last), 0);
        #2;
        clear = 1'b1;
        set_req(0, 8'hB0, 3'd1);
        set_req(1, 8'hB1, 3'd1);
        input_valid = 3'b011;
        #1;
        check_idle_zero("mid_clear");
        check("mid_clear_data", 32'(output_data), 0);
        check("mid_clear_src", 32'(output_source), 0);
        check("mid_clear_ready", 32'(input_ready), 0);
        tick();
        clear = 1'b0;
        #1;
        check("mid_after_ready", 32'(input_ready), 32'b001);
        tick();
        check("mid_after_data", 32'(output_data), 32'hB0);
        check("mid_after_src", 32'(output_source), 0);

        // Random traffic against a reference model
        clear = 1'b1;
        input_valid = '0;
        tick();
        clear = 1'b0;
        mptr = 0;
        mbusy = 1'b0;
        mrem = 0;
        msrc = 0;
        mdata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            input_valid = N'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) set_req(i, W'($urandom), CW'($urandom_range(0, 7)));
            output_ready = ($urandom_range(0, 3) != 0);
            #1;
            er = '0;
            g = -1;
            if (!mbusy) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (input_valid[(mptr + k) % N]) g = (mptr + k) % N;
                end
                if (g >= 0) er[g] = 1'b1;
            end
            check("rnd_ready", 32'(input_ready), 32'(er));
            check("rnd_onehot", 32'($countones(input_ready) <= 1), 1);
            check("rnd_busy", 32'(busy), 32'(mbusy));
            check("rnd_ov", 32'(output_valid), 32'(mbusy));
            if (mbusy) begin
                check("rnd_data", 32'(output_data), 32'(mdata));
                check("rnd_src", 32'(output_source), 32'(msrc));
                check("rnd_last", 32'(output_last), 32'(mrem == 1));
            end
            if (g >= 0) begin
                c = int'(input_repeat_count[g*CW +: CW]);
                if (c > MX) c = MX;
                mptr = (g + 1) % N;
                if (c > 0) begin
                    mbusy = 1'b1;
                    mrem = c;
                    msrc = g;
                    mdata = input_data[g*W +: W];
                end
            end else if (mbusy && output_ready) begin
                mrem--;
                if (mrem == 0) mbusy = 1'b0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
